acrtc_mbus_capture: RTL and testbench
=====================================

ACRTC_MBUS_CAPTURE -- requirements
Module: acrtc_mbus_capture

Interface
REQ-001 Parameter DATA_W, default 16, ACRTC memory-bus data width; output word is 2*DATA_W wide.
REQ-002 Parameter ADDR_W, default 14, valid low address bits; ADDR_W < DATA_W.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flops per bus input; legal range 1..4.
REQ-004 Parameter MAX_BURST, default 4, data beats accepted per address phase; legal range 1..16.
REQ-005 clk  in  1  system clock; all logic on rising edge, no negedge flops.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 bus_data  in  DATA_W  ACRTC multiplexed address/data bus.
REQ-008 bus_as, bus_2clk, bus_mrd, bus_draw  in  1 each  ACRTC address strobe, 2CLK, memory read (low = idle/abort), draw-cycle flag.
REQ-009 draw_only  in  1  mode: 1 = capture only phases with bus_draw high at address latch.
REQ-010 fb_out_full  in  1  downstream FIFO full.
REQ-011 fb_out_wen  out  1  one-cycle write strobe.
REQ-012 fb_out_wd  out  2*DATA_W  {zero-extended address in upper DATA_W bits, data in lower DATA_W bits}.
REQ-013 drop_clr  in  1  clears drop_cnt.
REQ-014 drop_cnt  out  16  saturating count of words lost to fb_out_full.
REQ-015 addr_err  out  1  one-cycle pulse per beat rejected for out-of-range address.

Function
REQ-016 All bus inputs pass through SYNC_STAGES flops; the FSM uses only the last stage.
REQ-017 States: IDLE, AS_LOW, AS_HIGH, LATCH, CK_LOW, CK_HIGH, CAPTURE, NEXT.
REQ-018 In any state other than LATCH/CAPTURE, synchronised bus_mrd low forces IDLE next cycle, no write, beat counter cleared.
REQ-019 IDLE -> AS_LOW when mrd high; AS_LOW -> AS_HIGH when as low; AS_HIGH -> LATCH when as high.
REQ-020 LATCH: latch address = bus_data, draw flag = bus_draw, beat count = 0; -> CK_LOW.
REQ-021 Phase is valid only if address bits [DATA_W-1:ADDR_W] are zero and (draw_only = 0 or draw flag = 1).
REQ-022 CK_LOW -> CK_HIGH when 2clk low; CK_HIGH -> CAPTURE when 2clk high.
REQ-023 CAPTURE samples bus_data in that cycle; fb_out_wen asserts the following cycle for exactly one cycle with fb_out_wd = {addr, data}.
REQ-024 Write occurs only if phase valid, current address <= 2^ADDR_W-1 and fb_out_full low in the CAPTURE cycle.
REQ-025 Valid beat with fb_out_full high: no write, drop_cnt increments, saturating at 16'hFFFF.
REQ-026 Beat with out-of-range address (incl. post-increment overflow): no write, addr_err pulses concurrently with where wen would be, drop_cnt unchanged; no address wrap to 0.
REQ-027 Phase invalid solely due to draw_only filtering: silently skipped, no addr_err, no drop.
REQ-028 NEXT: address += 1, beat count += 1; if as low -> AS_HIGH (new phase); else if beat count < MAX_BURST -> CK_LOW; else -> AS_LOW.
REQ-029 drop_clr and drop event in same cycle: result drop_cnt = 1.
REQ-030 fb_out_wd holds last written value between strobes; fb_out_wen never asserts on consecutive cycles.
REQ-031 draw_only is sampled only in LATCH; changes mid-phase have no effect on the current phase.

Reset
REQ-032 rst high: state IDLE, fb_out_wen 0, fb_out_wd 0, drop_cnt 0, addr_err 0, synchroniser flops 0, latched address/beat count 0.
REQ-033 rst mid-phase aborts without any write; first capture after reset requires a full IDLE->LATCH sequence.

Verification
REQ-034 Defaults, mrd high, AS pulse with data 16'h0123, one 2CLK cycle with data 16'hBEEF -> one wen, wd = 32'h0123_BEEF.
REQ-035 Address 16'h3FFE, 4 2CLK beats data 1..4 -> writes at 3FFE, 3FFF; beats 3-4 give two addr_err pulses, no wen.
REQ-036 Address 16'h4000 -> no wen, addr_err per beat; draw_only=1 with bus_draw low -> no wen, no addr_err.
REQ-037 fb_out_full high for 3 valid beats, drop_clr same cycle as 3rd drop -> drop_cnt = 1, no wen.
REQ-038 mrd low between CK_LOW and CK_HIGH -> no wen; rst asserted in CK_HIGH -> all outputs 0, no wen.
REQ-039 MAX_BURST=2, 3 2CLK cycles without new AS -> exactly 2 writes at addr, addr+1; third ignored until next AS.

Source files
------------

// File: rtl/acrtc_mbus_capture.sv
// rtl/acrtc_mbus_capture.sv - ACRTC memory-bus snoop that captures address/data beats into a FIFO
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus_data        ACRTC multiplexed address/data bus (asynchronous)
//   bus_as          address strobe (asynchronous)
//   bus_2clk        2CLK data-beat clock (asynchronous)
//   bus_mrd         memory read, low = idle/abort (asynchronous)
//   bus_draw        draw-cycle flag, latched with the address (asynchronous)
//   draw_only       1 = capture only phases flagged as draw cycles
//   fb_out_full     downstream FIFO full
//   fb_out_wen      one-cycle write strobe
//   fb_out_wd       {zero-extended address, data}, held between strobes
//   drop_clr        clears drop_cnt
//   drop_cnt        saturating count of beats lost to fb_out_full
//   addr_err        one-cycle pulse per beat rejected for out-of-range address
module acrtc_mbus_capture #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 14,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     bus_data,
  input  logic                  bus_as,
  input  logic                  bus_2clk,
  input  logic                  bus_mrd,
  input  logic                  bus_draw,
  input  logic                  draw_only,
  input  logic                  fb_out_full,
  output logic                  fb_out_wen,
  output logic [2*DATA_W-1:0]   fb_out_wd,
  input  logic                  drop_clr,
  output logic [15:0]           drop_cnt,
  output logic                  addr_err
);

  typedef enum logic [2:0] {
    IDLE, AS_LOW, AS_HIGH, LATCH, CK_LOW, CK_HIGH, CAPTURE, NEXT
  } state_t;

  localparam int                SW        = DATA_W + 4;
  localparam logic [DATA_W-1:0] ADDR_MAX  = {{(DATA_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};
  localparam logic [DATA_W-1:0] ADDR_TOP  = '1;
  localparam logic [4:0]        BURST_LIM = 5'(MAX_BURST);

  // All bus inputs share one synchroniser chain: {as, 2clk, mrd, draw, data}
  logic [SW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus_as, bus_2clk, bus_mrd, bus_draw, bus_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [SW-1:0]     s_vec;
  logic [DATA_W-1:0] s_data;
  logic              s_draw, s_mrd, s_2clk, s_as;

  assign s_vec  = sync_q[SYNC_STAGES-1];
  assign s_data = s_vec[DATA_W-1:0];
  assign s_draw = s_vec[DATA_W];
  assign s_mrd  = s_vec[DATA_W+1];
  assign s_2clk = s_vec[DATA_W+2];
  assign s_as   = s_vec[DATA_W+3];

  state_t            state;
  logic [DATA_W-1:0] addr_q;
  logic [4:0]        beat_q;
  logic              draw_ok_q;
  logic              addr_ok;
  logic              drop_ev;
  logic [4:0]        beat_next;

  // addr_q saturates instead of wrapping, so a single compare covers both
  // the latched upper bits and post-increment overflow.
  assign addr_ok   = (addr_q <= ADDR_MAX);
  assign drop_ev   = (state == CAPTURE) && addr_ok && draw_ok_q && fb_out_full;
  assign beat_next = beat_q + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      draw_ok_q  <= 1'b0;
      fb_out_wen <= 1'b0;
      fb_out_wd  <= '0;
      addr_err   <= 1'b0;
    end else begin
      fb_out_wen <= 1'b0;
      addr_err   <= 1'b0;
      if (!s_mrd && state != LATCH && state != CAPTURE) begin
        state  <= IDLE;
        beat_q <= '0;
      end else begin
        case (state)
          IDLE:    state <= AS_LOW;
          AS_LOW:  if (!s_as) state <= AS_HIGH;
          AS_HIGH: if (s_as)  state <= LATCH;
          LATCH: begin
            addr_q    <= s_data;
            draw_ok_q <= !draw_only || s_draw;
            beat_q    <= '0;
            state     <= CK_LOW;
          end
          CK_LOW:  if (!s_2clk) state <= CK_HIGH;
          CK_HIGH: if (s_2clk)  state <= CAPTURE;
          CAPTURE: begin
            // Address errors take priority; draw filtering is silent.
            if (!addr_ok) begin
              addr_err <= 1'b1;
            end else if (draw_ok_q && !fb_out_full) begin
              fb_out_wen <= 1'b1;
              fb_out_wd  <= {addr_q, s_data};
            end
            state <= NEXT;
          end
          NEXT: begin
            if (addr_q != ADDR_TOP) addr_q <= addr_q + DATA_W'(1);
            beat_q <= beat_next;
            if (!s_as)                      state <= AS_HIGH;
            else if (beat_next < BURST_LIM) state <= CK_LOW;
            else                            state <= AS_LOW;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A clear coinciding with a drop leaves exactly that one drop counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= drop_ev ? 16'd1 : 16'd0;
    end else if (drop_ev && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_acrtc_mbus_capture.sv
// tb/tb_acrtc_mbus_capture.sv - self-checking bench for acrtc_mbus_capture
module tb_acrtc_mbus_capture;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_data;
  logic        bus_as, bus_2clk, bus_mrd, bus_draw, draw_only, fb_out_full, drop_clr;
  logic        wen_a, wen_b, err_a, err_b;
  logic [31:0] wd_a, wd_b;
  logic [15:0] drop_a, drop_b;

  always #5 clk = ~clk;

  acrtc_mbus_capture #(.DATA_W(16), .ADDR_W(14), .SYNC_STAGES(SYNC), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .bus_data(bus_data), .bus_as(bus_as), .bus_2clk(bus_2clk),
    .bus_mrd(bus_mrd), .bus_draw(bus_draw), .draw_only(draw_only), .fb_out_full(fb_out_full),
    .fb_out_wen(wen_a), .fb_out_wd(wd_a), .drop_clr(drop_clr), .drop_cnt(drop_a), .addr_err(err_a)
  );

  acrtc_mbus_capture #(.DATA_W(16), .ADDR_W(14), .SYNC_STAGES(SYNC), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst), .bus_data(bus_data), .bus_as(bus_as), .bus_2clk(bus_2clk),
    .bus_mrd(bus_mrd), .bus_draw(bus_draw), .draw_only(draw_only), .fb_out_full(fb_out_full),
    .fb_out_wen(wen_b), .fb_out_wd(wd_b), .drop_clr(drop_clr), .drop_cnt(drop_b), .addr_err(err_b)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          maxb [2] = '{4, 2};
  logic [31:0] m_wd [2];
  logic [15:0] m_drop [2];
  int          obs_w [2];
  int          obs_e [2];
  int          obs_c [2];
  logic        prev_w [2];
  logic [15:0] beat_data [16];
  logic        beat_full [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (wen_a) begin obs_w[0]++; if (prev_w[0]) obs_c[0]++; end
      if (wen_b) begin obs_w[1]++; if (prev_w[1]) obs_c[1]++; end
      if (err_a) obs_e[0]++;
      if (err_b) obs_e[1]++;
      prev_w[0] = wen_a;
      prev_w[1] = wen_b;
    end
  endtask

  task automatic check_inst(input int i, input string tag, input int ew, input int ee);
    logic [31:0] wd;
    logic [15:0] dc;
    wd = (i == 0) ? wd_a : wd_b;
    dc = (i == 0) ? drop_a : drop_b;
    check($sformatf("%s.%0d.wen_count", tag, i), 32'(obs_w[i]), 32'(ew));
    check($sformatf("%s.%0d.err_count", tag, i), 32'(obs_e[i]), 32'(ee));
    check($sformatf("%s.%0d.wd", tag, i), wd, m_wd[i]);
    check($sformatf("%s.%0d.drop_cnt", tag, i), {16'd0, dc}, {16'd0, m_drop[i]});
    check($sformatf("%s.%0d.wen_back_to_back", tag, i), 32'(obs_c[i]), 32'd0);
    obs_w[i] = 0;
    obs_e[i] = 0;
    obs_c[i] = 0;
  endtask

  // Reference: beat k of a phase starting at address a, for an instance
  // whose burst limit is maxb[i].
  task automatic model_beat(input int i, input logic [15:0] a, input int k, input bit draw_ok,
                            input logic [15:0] d, input bit full, input bit clr,
                            output int ew, output int ee);
    int addr;
    bit dropped;
    ew = 0;
    ee = 0;
    dropped = 0;
    addr = int'(a) + k;
    if (k < maxb[i]) begin
      if (addr > 16383) ee = 1;
      else if (draw_ok) begin
        if (full) dropped = 1;
        else begin
          ew = 1;
          m_wd[i] = {addr[15:0], d};
        end
      end
    end
    if (clr) m_drop[i] = dropped ? 16'd1 : 16'd0;
    else if (dropped && m_drop[i] != 16'hFFFF) m_drop[i] = m_drop[i] + 16'd1;
  endtask

  task automatic run_phase(input string tag, input logic [15:0] addr, input bit draw,
                           input bit donly, input int nbeats, input int clr_beat);
    int ew [2];
    int ee [2];
    bit draw_ok;
    draw_ok = !donly || draw;
    bus_mrd = 1'b0; bus_as = 1'b1; bus_2clk = 1'b1; drop_clr = 1'b0;
    tick(6);
    bus_mrd = 1'b1; bus_data = addr; bus_draw = draw; draw_only = donly;
    tick(6);
    bus_as = 1'b0;
    tick(6);
    bus_as = 1'b1;
    tick(6);
    for (int b = 0; b < nbeats; b++) begin
      bus_2clk = 1'b0; bus_data = beat_data[b]; fb_out_full = beat_full[b];
      draw_only = 1'($urandom); bus_draw = 1'($urandom);
      tick(6);
      bus_2clk = 1'b1;
      // the capture edge is SYNC+2 edges after 2CLK rises
      tick(SYNC + 1);
      if (b == clr_beat) drop_clr = 1'b1;
      tick(1);
      drop_clr = 1'b0;
      tick(4);
      for (int i = 0; i < 2; i++) begin
        model_beat(i, addr, b, draw_ok, beat_data[b], beat_full[b], b == clr_beat, ew[i], ee[i]);
        check_inst(i, $sformatf("%s.b%0d", tag, b), ew[i], ee[i]);
      end
    end
  endtask

  task automatic set_beats(input int n, input logic [15:0] base, input bit full);
    for (int b = 0; b < 16; b++) begin
      beat_data[b] = base + 16'(b);
      beat_full[b] = (b < n) ? full : 1'b0;
    end
  endtask

  initial begin
    logic [15:0] ra;
    int          nb;
    for (int i = 0; i < 2; i++) begin
      m_wd[i] = '0; m_drop[i] = '0; obs_w[i] = 0; obs_e[i] = 0; obs_c[i] = 0; prev_w[i] = 1'b0;
    end
    rst = 1'b1; bus_data = '0; bus_as = 1'b1; bus_2clk = 1'b1; bus_mrd = 1'b0;
    bus_draw = 1'b0; draw_only = 1'b0; fb_out_full = 1'b0; drop_clr = 1'b0;
    tick(3);
    check("reset.wen_a", {31'd0, wen_a}, 32'd0);
    check("reset.wd_a", wd_a, 32'd0);
    check("reset.drop_a", {16'd0, drop_a}, 32'd0);
    check("reset.err_a", {31'd0, err_a}, 32'd0);
    check("reset.wd_b", wd_b, 32'd0);
    rst = 1'b0;

    set_beats(1, 16'hBEEF, 1'b0);
    run_phase("basic", 16'h0123, 1'b0, 1'b0, 1, -1);
    check("basic.wd_literal", wd_a, 32'h0123_BEEF);

    set_beats(4, 16'h0001, 1'b0);
    run_phase("top_edge", 16'h3FFE, 1'b0, 1'b0, 4, -1);

    set_beats(2, 16'h5A00, 1'b0);
    run_phase("oor", 16'h4000, 1'b1, 1'b0, 2, -1);
    run_phase("draw_filt", 16'h0010, 1'b0, 1'b1, 2, -1);
    run_phase("draw_pass", 16'h0020, 1'b1, 1'b1, 2, -1);

    set_beats(3, 16'hC000, 1'b0);
    run_phase("burst", 16'h0200, 1'b0, 1'b0, 3, -1);

    set_beats(3, 16'hD000, 1'b1);
    run_phase("drop_clr", 16'h0100, 1'b0, 1'b0, 3, 2);
    check("drop_clr.literal", {16'd0, drop_a}, 32'd1);

    for (int p = 0; p < 24; p++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom_range(0, 16383));
        1:       ra = 16'($urandom_range(16378, 16383));
        2:       ra = 16'($urandom_range(16384, 65535));
        default: ra = 16'($urandom_range(65532, 65535));
      endcase
      nb = $urandom_range(1, 5);
      for (int b = 0; b < 16; b++) begin
        beat_data[b] = 16'($urandom);
        beat_full[b] = ($urandom_range(0, 3) == 0);
      end
      run_phase($sformatf("rnd%0d", p), ra, 1'($urandom), 1'($urandom), nb, -1);
    end

    set_beats(0, 16'h0000, 1'b0);
    run_phase("abort", 16'h0050, 1'b0, 1'b0, 0, -1);
    bus_2clk = 1'b0; bus_data = 16'h7777;
    tick(6);
    bus_mrd = 1'b0;
    tick(6);
    bus_mrd = 1'b1;
    tick(6);
    bus_2clk = 1'b1;
    tick(8);
    check_inst(0, "abort", 0, 0);
    check_inst(1, "abort", 0, 0);

    run_phase("rst_mid", 16'h0060, 1'b0, 1'b0, 0, -1);
    bus_2clk = 1'b0; bus_data = 16'h8888;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("rst_mid.wen_a", {31'd0, wen_a}, 32'd0);
    check("rst_mid.wd_a", wd_a, 32'd0);
    check("rst_mid.drop_a", {16'd0, drop_a}, 32'd0);
    check("rst_mid.err_a", {31'd0, err_a}, 32'd0);
    check("rst_mid.wd_b", wd_b, 32'd0);
    check("rst_mid.drop_b", {16'd0, drop_b}, 32'd0);
    for (int i = 0; i < 2; i++) begin m_wd[i] = '0; m_drop[i] = '0; end
    tick(1);
    rst = 1'b0;
    bus_2clk = 1'b1;
    tick(8);
    check_inst(0, "rst_mid.after", 0, 0);
    check_inst(1, "rst_mid.after", 0, 0);

    set_beats(1, 16'($urandom), 1'b0);
    run_phase("post_rst", 16'h1234, 1'b0, 1'b0, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
